// File: rtl/ascii_case_pkg.sv
// Shared constants and types for the ASCII case-conversion stream.
package ascii_case_pkg;

  typedef enum logic [1:0] {
    MODE_PASS   = 2'd0,
    MODE_UPPER  = 2'd1,
    MODE_LOWER  = 2'd2,
    MODE_TOGGLE = 2'd3
  } case_mode_e;

  localparam logic [7:0] LOWER_A = 8'h61;
  localparam logic [7:0] LOWER_Z = 8'h7A;
  localparam logic [7:0] UPPER_A = 8'h41;
  localparam logic [7:0] UPPER_Z = 8'h5A;

  localparam int unsigned CASE_BIT = 5;

endpackage

// File: rtl/ascii_case_stream_if.sv
// Valid/ready character stream, LANES characters per beat, lane 0 first.
interface ascii_case_stream_if #(
  parameter int unsigned LANES = 4
);
  localparam int unsigned DATA_W = 8 * LANES;

  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic              last;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);

endinterface

// File: rtl/ascii_case_lane.sv
// Single-character case converter; flags whether the character changed.
module ascii_case_lane
  import ascii_case_pkg::*;
(
  input  logic [7:0] char_i,
  input  case_mode_e mode_i,
  output logic [7:0] char_c,
  output logic       changed_c
);

  logic is_lower;
  logic is_upper;
  logic flip;

  // Classify the character and decide whether its case bit flips.
  always_comb begin
    is_lower = (char_i >= LOWER_A) && (char_i <= LOWER_Z);
    is_upper = (char_i >= UPPER_A) && (char_i <= UPPER_Z);
    flip     = 1'b0;
    case (mode_i)
      MODE_UPPER:  flip = is_lower;
      MODE_LOWER:  flip = is_upper;
      MODE_TOGGLE: flip = is_lower | is_upper;
      default:     flip = 1'b0;
    endcase
    char_c    = char_i ^ (8'(flip) << CASE_BIT);
    changed_c = flip;
  end

endmodule

// File: rtl/ascii_case_stream.sv
// Pipelined multi-lane case converter with skid buffer and saturating change counter.
module ascii_case_stream
  import ascii_case_pkg::*;
#(
  parameter int unsigned LANES = 4,
  parameter int unsigned CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           mode,
  input  logic                 clr_count,
  output logic [CNT_W-1:0]     conv_count,
  ascii_case_stream_if.slave   s_if,
  ascii_case_stream_if.master  m_if
);

  localparam int unsigned DATA_W = 8 * LANES;
  localparam int unsigned NCHG_W = $clog2(LANES + 1);
  localparam int unsigned SUM_W  = ((CNT_W > NCHG_W) ? CNT_W : NCHG_W) + 1;
  localparam logic [SUM_W-1:0] CNT_MAX = SUM_W'({CNT_W{1'b1}});

  logic [DATA_W-1:0] conv_data_c;
  logic [LANES-1:0]  lane_chg_c;
  logic [NCHG_W-1:0] nchg_c;
  logic              accept_c;
  logic              consume_c;
  logic [CNT_W-1:0]  cnt_base_c;
  logic [SUM_W-1:0]  cnt_sum_c;

  logic              ready_q,     ready_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;
  logic              out_last_q,  out_last_d;
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] skid_data_q,  skid_data_d;
  logic              skid_last_q,  skid_last_d;
  logic [CNT_W-1:0]  count_q,     count_d;

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    ascii_case_lane u_lane (
      .char_i    (s_if.data[8*k +: 8]),
      .mode_i    (case_mode_e'(mode)),
      .char_c    (conv_data_c[8*k +: 8]),
      .changed_c (lane_chg_c[k])
    );
  end

  // Number of lanes whose character changed in the incoming beat.
  always_comb begin
    nchg_c = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      nchg_c = nchg_c + NCHG_W'(lane_chg_c[k]);
    end
  end

  // Output register / skid buffer steering; skid drains into output first.
  always_comb begin
    accept_c     = s_if.valid & ready_q;
    consume_c    = out_valid_q & m_if.ready;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_last_d   = out_last_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_last_d  = skid_last_q;
    if (!out_valid_q || consume_c) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        out_last_d   = skid_last_q;
        skid_valid_d = 1'b0;
      end else if (accept_c) begin
        out_valid_d = 1'b1;
        out_data_d  = conv_data_c;
        out_last_d  = s_if.last;
      end else begin
        out_valid_d = 1'b0;
      end
    end else if (accept_c) begin
      skid_valid_d = 1'b1;
      skid_data_d  = conv_data_c;
      skid_last_d  = s_if.last;
    end
    ready_d = ~skid_valid_d;
  end

  // Saturating change counter; clear applies before the same-edge increment.
  always_comb begin
    cnt_base_c = clr_count ? '0 : count_q;
    cnt_sum_c  = SUM_W'(cnt_base_c) + SUM_W'(nchg_c);
    count_d    = cnt_base_c;
    if (accept_c) begin
      count_d = (cnt_sum_c > CNT_MAX) ? CNT_W'(CNT_MAX) : CNT_W'(cnt_sum_c);
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_q      <= 1'b1;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_last_q  <= 1'b0;
      count_q      <= '0;
    end else begin
      ready_q      <= ready_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_last_q  <= skid_last_d;
      count_q      <= count_d;
    end
  end

  assign s_if.ready = ready_q;
  assign m_if.valid = out_valid_q;
  assign m_if.data  = out_data_q;
  assign m_if.last  = out_last_q;
  assign conv_count = count_q;

endmodule

// File: tb/tb_ascii_case_stream.sv
// Randomized and directed bench for ascii_case_stream against a queue-based reference.
module tb_ascii_case_stream;

  localparam int unsigned LANES = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  in_mode = 2'd0;
  logic        in_clr = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] cnt;
  logic [3:0]  cnt_sat;

  always #5 clk = ~clk;

  ascii_case_stream_if #(.LANES(LANES)) s_if ();
  ascii_case_stream_if #(.LANES(LANES)) m_if ();
  ascii_case_stream_if #(.LANES(LANES)) s2_if ();
  ascii_case_stream_if #(.LANES(LANES)) m2_if ();

  assign s_if.valid  = in_valid;
  assign s_if.data   = in_data;
  assign s_if.last   = in_last;
  assign m_if.ready  = out_ready;
  assign s2_if.valid = in_valid;
  assign s2_if.data  = in_data;
  assign s2_if.last  = in_last;
  assign m2_if.ready = out_ready;

  ascii_case_stream #(.LANES(LANES), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .mode(in_mode), .clr_count(in_clr),
    .conv_count(cnt), .s_if(s_if), .m_if(m_if)
  );

  ascii_case_stream #(.LANES(LANES), .CNT_W(4)) dut_sat (
    .clk(clk), .rst_n(rst_n), .mode(in_mode), .clr_count(in_clr),
    .conv_count(cnt_sat), .s_if(s2_if), .m_if(m2_if)
  );

  typedef struct packed {
    logic [31:0] data;
    logic        last;
  } beat_t;

  beat_t q[$];
  int unsigned cnt_m, cnt_s;
  int n_tests = 0;
  int n_fail = 0;
  int obs_emit = 0;
  int obs_last_idx = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: ASCII letters differ in case by exactly 32.
  function automatic logic [7:0] ref_char(input logic [7:0] c, input logic [1:0] m);
    int v;
    bit low, up;
    v   = int'(c);
    low = (v >= 97) && (v <= 122);
    up  = (v >= 65) && (v <= 90);
    case (m)
      2'd1: if (low) v = v - 32;
      2'd2: if (up) v = v + 32;
      2'd3: begin
        if (low) v = v - 32;
        else if (up) v = v + 32;
      end
      default: ;
    endcase
    return 8'(v);
  endfunction

  function automatic logic [31:0] ref_beat(input logic [31:0] d, input logic [1:0] m);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) r[8*k +: 8] = ref_char(d[8*k +: 8], m);
    return r;
  endfunction

  function automatic int ref_changes(input logic [31:0] d, input logic [1:0] m);
    int n = 0;
    for (int k = 0; k < 4; k++) if (ref_char(d[8*k +: 8], m) != d[8*k +: 8]) n++;
    return n;
  endfunction

  task automatic compare_all();
    check("s_ready", s_if.ready, (q.size() < 2));
    check("m_valid", m_if.valid, (q.size() > 0));
    if (q.size() > 0) begin
      check("m_data", m_if.data, q[0].data);
      check("m_last", m_if.last, q[0].last);
    end
    check("count", cnt, cnt_m);
    check("count_sat", cnt_sat, cnt_s);
  endtask

  // One clock: inputs are already set; update model at the edge, compare at negedge.
  task automatic cycle();
    bit acc, con;
    beat_t b;
    int n;
    acc = in_valid && (q.size() < 2);
    con = out_ready && (q.size() > 0);
    if (m_if.valid && out_ready) begin
      obs_emit++;
      if (m_if.last) obs_last_idx = obs_emit;
    end
    @(posedge clk);
    if (con) b = q.pop_front();
    if (acc) begin
      b.data = ref_beat(in_data, in_mode);
      b.last = in_last;
      q.push_back(b);
    end
    if (in_clr) begin
      cnt_m = 0;
      cnt_s = 0;
    end
    if (acc) begin
      n = ref_changes(in_data, in_mode);
      cnt_m = (cnt_m + n > 65535) ? 65535 : cnt_m + n;
      cnt_s = (cnt_s + n > 15) ? 15 : cnt_s + n;
    end
    @(negedge clk);
    compare_all();
  endtask

  // Asynchronous reset assertion mid-cycle; called and returns at a negedge.
  task automatic do_reset();
    #2;
    rst_n = 1'b0;
    q.delete();
    cnt_m = 0;
    cnt_s = 0;
    #1;
    check("rst_m_valid", m_if.valid, 1'b0);
    check("rst_s_ready", s_if.ready, 1'b1);
    check("rst_m_data", m_if.data, 32'h0);
    check("rst_m_last", m_if.last, 1'b0);
    check("rst_count", cnt, 16'h0);
    check("rst_count_sat", cnt_sat, 4'h0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic send(input logic [1:0] m, input logic [31:0] d);
    in_mode   = m;
    in_data   = d;
    in_valid  = 1'b1;
    in_last   = 1'b0;
    out_ready = 1'b1;
    cycle();
  endtask

  function automatic logic [7:0] rand_char();
    if ($urandom_range(1, 0) == 1) return 8'($urandom_range(8'h7B, 8'h40));
    return 8'($urandom);
  endfunction

  initial begin
    logic [31:0] held;
    int sent;
    bit will_acc;

    @(negedge clk);
    do_reset();

    // Upper conversion
    send(2'd1, 32'h7B5A6261);
    check("up_data", m_if.data, 32'h7B5A4241);
    check("up_cnt", cnt, 16'd2);

    // Boundaries never change in any mode
    for (int m = 0; m < 4; m++) begin
      send(2'(m), 32'h7B605B40);
      check("bound_data", m_if.data, 32'h7B605B40);
      check("bound_cnt", cnt, 16'd2);
    end

    // Lower, toggle, high-bit bytes
    send(2'd2, 32'h5A416261);
    check("low_data", m_if.data, 32'h7A616261);
    check("low_cnt", cnt, 16'd4);
    send(2'd3, 32'h5A416261);
    check("tog_data", m_if.data, 32'h7A614241);
    check("tog_cnt", cnt, 16'd8);
    send(2'd3, 32'hC1E16261);
    check("hi_data", m_if.data, 32'hC1E14241);
    check("hi_cnt", cnt, 16'd10);
    in_valid = 1'b0;
    cycle();

    // Backpressure: 5 beats, m_ready low for 3 cycles after first accept
    sent = 0;
    obs_emit = 0;
    obs_last_idx = 0;
    held = ref_beat(32'h64636261, 2'd1);
    in_mode = 2'd1;
    for (int cyc = 0; cyc < 14; cyc++) begin
      in_valid  = (sent < 5);
      in_data   = 32'h64636261 + 32'(sent);
      in_last   = (sent == 4);
      out_ready = (cyc >= 4);
      will_acc  = in_valid && (q.size() < 2);
      cycle();
      if (will_acc) sent++;
      if (cyc == 1) check("bp_sready_low", s_if.ready, 1'b0);
      if (cyc >= 1 && cyc <= 3) check("bp_stable", m_if.data, held);
    end
    check("bp_emitted", 32'(obs_emit), 32'd5);
    check("bp_last_idx", 32'(obs_last_idx), 32'd5);
    in_valid = 1'b0;
    in_last  = 1'b0;

    // Saturation on the narrow counter, then clear with same-edge accept
    in_clr = 1'b1;
    cycle();
    in_clr = 1'b0;
    for (int i = 0; i < 5; i++) send(2'd3, 32'h64636261);
    check("sat_hold", cnt_sat, 4'd15);
    in_clr = 1'b1;
    send(2'd3, 32'h32314261);
    check("clr_acc_sat", cnt_sat, 4'd2);
    check("clr_acc", cnt, 16'd2);
    in_clr = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(3, 0) != 0);
      in_data   = {rand_char(), rand_char(), rand_char(), rand_char()};
      in_last   = ($urandom_range(3, 0) == 0);
      in_mode   = 2'($urandom_range(3, 0));
      in_clr    = ($urandom_range(19, 0) == 0);
      out_ready = ($urandom_range(2, 0) != 0);
      cycle();
    end
    in_clr = 1'b0;

    // Reset with two beats stored
    in_valid  = 1'b0;
    out_ready = 1'b1;
    cycle();
    out_ready = 1'b0;
    in_mode   = 2'd1;
    in_valid  = 1'b1;
    in_data   = 32'h61616161;
    cycle();
    in_data   = 32'h62626262;
    cycle();
    check("pre_rst_full", s_if.ready, 1'b0);
    in_valid = 1'b0;
    do_reset();
    send(2'd1, 32'h7A7A2179);
    check("post_rst_valid", m_if.valid, 1'b1);
    check("post_rst_data", m_if.data, 32'h5A5A2159);
    in_valid = 1'b0;
    cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ascii_case_stream.md
Name: ascii_case_stream

Overview:
- Parametrised, pipelined successor to the 8-bit combinational upper-case converter.
- Converts a stream of ASCII characters, LANES characters per beat, under a run-time selectable case mode.
- Uses a valid/ready handshake with a skid buffer, so it can sit between any two streaming stages of the text path.
- Keeps a saturating count of characters whose case was changed.

Parameters:
- LANES, 4, characters per beat; legal range 1 to 16.
- CNT_W, 16, width of the converted-character counter.

Ports:
- clk  in  1  single clock; everything is sampled on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- mode  in  2  case mode: 0 pass, 1 upper, 2 lower, 3 toggle. Sampled per beat at acceptance.
- s_valid  in  1  input beat valid.
- s_ready  out  1  block can accept an input beat.
- s_data  in  8*LANES  input characters; lane k is bits [8k+7:8k], lane 0 first in text order.
- s_last  in  1  marks the final beat of a string.
- m_valid  out  1  output beat valid.
- m_ready  in  1  downstream accepts the output beat.
- m_data  out  8*LANES  converted characters, same lane order.
- m_last  out  1  s_last carried with its beat.
- clr_count  in  1  synchronous clear of conv_count.
- conv_count  out  CNT_W  saturating count of characters whose value changed.

Behaviour:
- Reset: while rst_n=0 the block is held in reset, and on release it starts in this state:
  - s_ready=1, m_valid=0, m_data=0, m_last=0, conv_count=0.
  - Skid buffer empty; the in-flight beat is discarded.
  - The first accept is possible on the first rising edge after rst_n rises.
- Accept and emit:
  - An input beat is accepted on an edge where s_valid&&s_ready.
  - An output beat is consumed on an edge where m_valid&&m_ready.
- Per-lane conversion (combinational, applied before the output register):
  - lower letter: 0x61..0x7A; upper letter: 0x41..0x5A.
  - Mode 1: a lower letter has bit5 cleared.
  - Mode 2: an upper letter has bit5 set.
  - Mode 3: any letter has bit5 flipped.
  - Mode 0, and all non-letters (including 0x40, 0x5B, 0x60, 0x7B and 0x80..0xFF), pass unchanged.
- Mode coherence: a mode change takes effect on the next accepted beat only. It never alters beats already stored.
- Latency and throughput:
  - Latency is 1 cycle: a beat accepted at edge N is on m_data/m_last with m_valid=1 after edge N.
  - Throughput is 1 beat per cycle while m_ready=1.
- Storage: output register plus a 1-entry skid buffer.
  - s_ready = skid buffer empty; it is a registered signal with no combinational path from m_ready.
  - An accept while the output register is occupied and not consumed goes into the skid buffer.
  - Skid contents move to the output register on the next consume.
  - Order is strictly preserved; no beat is dropped or duplicated.
- Stall: while m_valid=1 and m_ready=0, m_data and m_last hold stable.
- Counter:
  - At each accept, conv_count += number of lanes whose value changed, saturating at 2^CNT_W-1.
  - clr_count=1 sets conv_count=0. If an accept happens on the same edge, conv_count = that beat's changed-lane count.
- Reset mid-operation:
  - Output and skid contents are lost and the outputs return to reset values.
  - The upstream source must re-send the unacknowledged beats.

Decomposition:
- Package ascii_case_pkg holds:
  - mode constants MODE_PASS=0, MODE_UPPER=1, MODE_LOWER=2, MODE_TOGGLE=3.
  - letter bounds LOWER_A=0x61, LOWER_Z=0x7A, UPPER_A=0x41, UPPER_Z=0x5A.
  - CASE_BIT=5.
- Sub-module ascii_case_lane:
  - Combinational, 8-bit char plus mode in; 8-bit char plus a changed flag out.
  - Instantiated LANES times by a generate loop.
- Top level holds the skid buffer, output register and counter.

Test Plan (LANES=4 unless noted):
- Upper conversion: mode=1, s_data=0x7B5A6261 ("abZ{"), m_ready=1.
  - Expect m_data=0x7B5A4241 one cycle after accept, and conv_count=2.
- Boundaries: s_data=0x7B605B40 in each of modes 0..3 → output unchanged and conv_count unchanged in every mode.
- Lower and toggle modes:
  - mode=2 with s_data=0x5A416261 → 0x7A616261, +2.
  - mode=3 with the same input → 0x7A614241, +4.
  - 0xC1E1 in the high bytes passes unchanged.
- Backpressure: stream 5 beats with s_last on beat 5, holding m_ready=0 for 3 cycles after the first accept.
  - Expect s_ready=0 after two beats are stored, and m_data stable throughout the stall.
  - After release, all 5 beats emerge in order with m_last only on beat 5, and no gaps while m_ready=1.
- Saturation and clear: CNT_W=4, mode=3, 5 beats of "abcd".
  - Expect conv_count to reach and hold 15.
  - Then clr_count=1 together with an accept of "aB12" → conv_count=2.
- Reset mid-stream: drop rst_n with 2 beats stored.
  - Expect m_valid=0, s_ready=1, conv_count=0 immediately.
  - After release, the first new beat emerges with 1-cycle latency.
